serial_word_deserializer: RTL

- Downstream consumer of the single-bit registered stream produced by the D-FF / 2:1 MUX stage.
- Assembles qualified serial bits into WIDTH-bit parallel words.
- Holds one completed word in an output register and presents it on a valid/ready handshake.
- Flags words lost to backpressure with a sticky overflow bit.

---
 rtl/serial_word_deserializer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler: collects qualified bits into WIDTH-bit words
// and presents each completed word on a valid/ready output register with sticky overflow.
module serial_word_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic [$clog2(WIDTH):0]     bit_count
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_base, shifted;
  logic [CW-1:0]    count_q, count_d;
  logic             complete;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // frame_start discards the partial word, so the incoming bit shifts into a cleared register
  always_comb begin
    shift_base = frame_start ? '0 : shift_q;
    shifted    = MSB_FIRST ? {shift_base[WIDTH-2:0], bit_in}
                           : {bit_in, shift_base[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    complete = 1'b0;

    if (frame_start) begin
      if (bit_valid) begin
        shift_d = shifted;
        count_d = CW'(1);
        state_d = COLLECT;
      end else begin
        shift_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    end else if (bit_valid) begin
      case (state_q)
        IDLE: begin
          shift_d = shifted;
          count_d = CW'(1);
          state_d = COLLECT;
        end
        COLLECT: begin
          if (count_q == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            shift_d  = '0;
            count_d  = '0;
            state_d  = IDLE;
          end else begin
            shift_d = shifted;
            count_d = count_q + CW'(1);
          end
        end
        default: begin
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as clear_ovf leaves overflow set
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (clear_ovf) begin
      ovf_d = 1'b0;
    end

    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;
  assign bit_count  = count_q;

endmodule
